// File: rtl/pulserain_rv2t_mcu.sv
// pulserain_rv2t_mcu: multi-cycle RV32I core with unified word RAM, OCD load/inspect port,
// instruction trace outputs and a store-driven 8N1 UART transmitter.
module pulserain_rv2t_mcu #(
    parameter int          MEM_ADDR_BITS = 12,
    parameter int          REG_ADDR_BITS = 5,
    parameter logic [31:0] UART_ADDR     = 32'h2000_0000,
    parameter int          BAUD_DIV      = 434
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     reset_n,
    input  logic                     ocd_read_enable,
    input  logic                     ocd_write_enable,
    input  logic [MEM_ADDR_BITS-1:0] ocd_rw_addr,
    input  logic [31:0]              ocd_write_word,
    output logic                     ocd_mem_enable_out,
    output logic [31:0]              ocd_mem_word_out,
    input  logic [REG_ADDR_BITS-1:0] ocd_reg_read_addr,
    input  logic                     ocd_reg_we,
    input  logic [REG_ADDR_BITS-1:0] ocd_reg_write_addr,
    input  logic [31:0]              ocd_reg_write_data,
    output logic                     TXD,
    input  logic                     start,
    input  logic [31:0]              start_address,
    output logic                     processor_paused,
    output logic [31:0]              peek_pc,
    output logic [31:0]              peek_ir,
    output logic [3:0]               peek_mem_write_en,
    output logic [31:0]              peek_mem_write_data,
    output logic [MEM_ADDR_BITS-1:0] peek_mem_addr
);
    localparam int MW = MEM_ADDR_BITS;
    localparam int RN = 1 << REG_ADDR_BITS;
    localparam logic [15:0] BAUD_M1 = 16'(BAUD_DIV - 1);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
        OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
        OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
        OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_PAUSED, S_FETCH, S_DECODE, S_EXEC, S_LOAD_WB, S_HALTED} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, ir_q, ir_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]       peek_pc_q, peek_pc_d, peek_ir_q, peek_ir_d;
    logic [9:0]        uart_sr_q, uart_sr_d;
    logic [15:0]       uart_cnt_q, uart_cnt_d;
    logic [3:0]        uart_bits_q, uart_bits_d;
    logic [31:0]       mem [0:(1<<MW)-1];
    logic [31:0]       rf [0:RN-1];
    logic [31:0]       rdata_q;
    logic [MW-1:0]     rd_addr;
    logic              rf_we, core_we, st_ram, is_uart, take, unused_ok;
    logic [REG_ADDR_BITS-1:0] rf_wa;
    logic [31:0]       rf_wd, core_wd, imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu, ls_addr;
    logic [31:0]       st_data, ld_val, rs1_rd, rs2_rd;
    logic [3:0]        st_be;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [4:0]        shamt;
    logic [1:0]        ls_off;

    assign unused_ok = ^{reset_n, ocd_reg_read_addr};

    assign opc   = ir_q[6:0];
    assign f3    = ir_q[14:12];
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign rs1_rd = (rdata_q[19:15] == 5'd0) ? 32'd0 : rf[REG_ADDR_BITS'(rdata_q[19:15])];
    assign rs2_rd = (rdata_q[24:20] == 5'd0) ? 32'd0 : rf[REG_ADDR_BITS'(rdata_q[24:20])];

    assign alu_b = (opc == OP_REG) ? rs2_q : imm_i;
    assign shamt = alu_b[4:0];
    always_comb begin
        case (f3)
            3'b000:  alu = (opc == OP_REG && ir_q[30]) ? rs1_q - alu_b : rs1_q + alu_b;
            3'b001:  alu = rs1_q << shamt;
            3'b010:  alu = {31'd0, $signed(rs1_q) < $signed(alu_b)};
            3'b011:  alu = {31'd0, rs1_q < alu_b};
            3'b100:  alu = rs1_q ^ alu_b;
            3'b101:  alu = ir_q[30] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
            3'b110:  alu = rs1_q | alu_b;
            default: alu = rs1_q & alu_b;
        endcase
    end

    assign take = (f3[2] ? (f3[1] ? rs1_q < rs2_q : $signed(rs1_q) < $signed(rs2_q))
                         : rs1_q == rs2_q) ^ f3[0];

    assign ls_addr = rs1_q + ((opc == OP_STORE) ? imm_s : imm_i);
    assign ls_off  = ls_addr[1:0];
    assign is_uart = ls_addr == UART_ADDR;
    assign st_be   = (f3[1:0] == 2'b00) ? 4'b0001 << ls_off :
                     (f3[1:0] == 2'b01) ? (ls_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign st_data = (f3[1:0] == 2'b00) ? {4{rs2_q[7:0]}} :
                     (f3[1:0] == 2'b01) ? {2{rs2_q[15:0]}} : rs2_q;
    assign st_ram  = state_q == S_EXEC && opc == OP_STORE && !is_uart;

    // Misaligned halves/words read within the aligned word; only the lane shift uses the offset.
    assign ld_b   = 8'(rdata_q >> {ls_off, 3'b000});
    assign ld_h   = 16'(rdata_q >> {ls_off[1], 4'b0000});
    assign ld_val = f3[1] ? rdata_q :
                    f3[0] ? {f3[2] ? 16'd0 : {16{ld_h[15]}}, ld_h} :
                            {f3[2] ? 24'd0 : {24{ld_b[7]}}, ld_b};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        peek_pc_d   = peek_pc_q;
        peek_ir_d   = peek_ir_q;
        uart_sr_d   = uart_sr_q;
        uart_cnt_d  = uart_cnt_q;
        uart_bits_d = uart_bits_q;
        core_we     = 1'b0;
        core_wd     = alu;
        rd_addr     = pc_q[MW+1:2];
        if (uart_bits_q != 4'd0) begin
            uart_cnt_d = (uart_cnt_q == 16'd0) ? BAUD_M1 : uart_cnt_q - 16'd1;
            if (uart_cnt_q == 16'd0) begin
                uart_sr_d   = {1'b1, uart_sr_q[9:1]};
                uart_bits_d = uart_bits_q - 4'd1;
            end
        end
        case (state_q)
            S_PAUSED: if (start) begin
                pc_d    = start_address;
                state_d = S_FETCH;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d      = rdata_q;
                peek_pc_d = pc_q;
                peek_ir_d = rdata_q;
                rs1_d     = rs1_rd;
                rs2_d     = rs2_rd;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_q + 32'd4;
                state_d = start ? S_FETCH : S_PAUSED;
                case (opc)
                    OP_LUI:    begin core_we = 1'b1; core_wd = imm_u; end
                    OP_AUIPC:  begin core_we = 1'b1; core_wd = pc_q + imm_u; end
                    OP_JAL:    begin core_we = 1'b1; core_wd = pc_q + 32'd4; pc_d = (pc_q + imm_j) & ~32'd3; end
                    OP_JALR:   begin core_we = 1'b1; core_wd = pc_q + 32'd4; pc_d = (rs1_q + imm_i) & ~32'd3; end
                    OP_BRANCH: pc_d = take ? (pc_q + imm_b) & ~32'd3 : pc_q + 32'd4;
                    OP_IMM, OP_REG: core_we = 1'b1;
                    OP_LOAD:   begin rd_addr = ls_addr[MW+1:2]; state_d = S_LOAD_WB; end
                    OP_STORE:  if (is_uart && uart_bits_q != 4'd0) begin
                        pc_d    = pc_q;
                        state_d = S_EXEC;
                    end else if (is_uart) begin
                        uart_sr_d   = {1'b1, rs2_q[7:0], 1'b0};
                        uart_cnt_d  = BAUD_M1;
                        uart_bits_d = 4'd10;
                    end
                    OP_FENCE:  ;
                    OP_SYSTEM: if (f3 == 3'b000) begin
                        pc_d    = pc_q;
                        state_d = S_HALTED;
                    end else begin
                        core_we = 1'b1;
                        core_wd = 32'd0;
                    end
                    default:   begin pc_d = pc_q; state_d = S_HALTED; end
                endcase
            end
            S_LOAD_WB: begin
                core_we = 1'b1;
                core_wd = ld_val;
                state_d = start ? S_FETCH : S_PAUSED;
            end
            default: state_d = start ? S_HALTED : S_PAUSED;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = REG_ADDR_BITS'(ir_q[11:7]);
        rf_wd = core_wd;
        if (core_we && ir_q[11:7] != 5'd0 && !sync_reset) rf_we = 1'b1;
        else if (processor_paused && ocd_reg_we && ocd_reg_write_addr != '0) begin
            rf_we = 1'b1;
            rf_wa = ocd_reg_write_addr;
            rf_wd = ocd_reg_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q     <= S_PAUSED;
            pc_q        <= 32'd0;
            ir_q        <= 32'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            peek_pc_q   <= 32'd0;
            peek_ir_q   <= 32'd0;
            uart_sr_q   <= 10'h3FF;
            uart_cnt_q  <= 16'd0;
            uart_bits_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            peek_pc_q   <= peek_pc_d;
            peek_ir_q   <= peek_ir_d;
            uart_sr_q   <= uart_sr_d;
            uart_cnt_q  <= uart_cnt_d;
            uart_bits_q <= uart_bits_d;
        end
    end

    // OCD writes take the single write port ahead of a same-cycle core store.
    always_ff @(posedge clk) begin
        if (ocd_write_enable) mem[ocd_rw_addr] <= ocd_write_word;
        else if (st_ram && !sync_reset)
            for (int i = 0; i < 4; i++)
                if (st_be[i]) mem[ls_addr[MW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
        rdata_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rf_wa] <= rf_wd;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            ocd_mem_enable_out <= 1'b0;
            ocd_mem_word_out   <= 32'd0;
        end else begin
            ocd_mem_enable_out <= ocd_read_enable;
            if (ocd_read_enable) ocd_mem_word_out <= mem[ocd_rw_addr];
        end
    end

    assign processor_paused    = state_q == S_PAUSED || state_q == S_HALTED;
    assign TXD                 = uart_sr_q[0];
    assign peek_pc             = peek_pc_q;
    assign peek_ir             = peek_ir_q;
    assign peek_mem_write_en   = st_ram ? st_be : 4'd0;
    assign peek_mem_write_data = st_ram ? st_data : 32'd0;
    assign peek_mem_addr       = st_ram ? ls_addr[MW+1:2] : '0;
endmodule

// File: tb/tb_pulserain_rv2t_mcu.sv
// tb_pulserain_rv2t_mcu: loads small programs over OCD and checks stores, UART frames and control.
module tb_pulserain_rv2t_mcu;
    localparam int MW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          sync_reset, reset_n, ocd_read_enable, ocd_write_enable, ocd_mem_enable_out;
    logic [MW-1:0] ocd_rw_addr, peek_mem_addr;
    logic [31:0]   ocd_write_word, ocd_mem_word_out, ocd_reg_write_data, start_address;
    logic [4:0]    ocd_reg_read_addr, ocd_reg_write_addr;
    logic          ocd_reg_we, TXD, start, processor_paused;
    logic [31:0]   peek_pc, peek_ir, peek_mem_write_data;
    logic [3:0]    peek_mem_write_en;

    pulserain_rv2t_mcu #(.BAUD_DIV(4)) dut (
        .clk(clk), .sync_reset(sync_reset), .reset_n(reset_n),
        .ocd_read_enable(ocd_read_enable), .ocd_write_enable(ocd_write_enable),
        .ocd_rw_addr(ocd_rw_addr), .ocd_write_word(ocd_write_word),
        .ocd_mem_enable_out(ocd_mem_enable_out), .ocd_mem_word_out(ocd_mem_word_out),
        .ocd_reg_read_addr(ocd_reg_read_addr), .ocd_reg_we(ocd_reg_we),
        .ocd_reg_write_addr(ocd_reg_write_addr), .ocd_reg_write_data(ocd_reg_write_data),
        .TXD(TXD), .start(start), .start_address(start_address),
        .processor_paused(processor_paused), .peek_pc(peek_pc), .peek_ir(peek_ir),
        .peek_mem_write_en(peek_mem_write_en), .peek_mem_write_data(peek_mem_write_data),
        .peek_mem_addr(peek_mem_addr)
    );

    typedef struct packed {
        logic [3:0]    en;
        logic [MW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   mask;
    } st_t;

    st_t         sb_q[$];
    st_t         mon_e;
    logic [7:0]  uart_q[$];
    logic [31:0] prog[$];
    int          tests = 0;
    int          fails = 0;

    // Scoreboard: every store strobe seen must match the oldest expected store.
    always @(negedge clk) begin
        if (!sync_reset && peek_mem_write_en !== 4'h0) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_store: got en=%h addr=%h data=%h, required no store",
                         peek_mem_write_en, peek_mem_addr, peek_mem_write_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (peek_mem_write_en !== mon_e.en || peek_mem_addr !== mon_e.addr ||
                    (peek_mem_write_data & mon_e.mask) !== (mon_e.data & mon_e.mask)) begin
                    fails++;
                    $display("FAIL store: got en=%h addr=%h data=%h, required en=%h addr=%h data=%h (mask %h)",
                             peek_mem_write_en, peek_mem_addr, peek_mem_write_data,
                             mon_e.en, mon_e.addr, mon_e.data, mon_e.mask);
                end
            end
        end
    end

    task automatic ocd_wr(input logic [MW-1:0] a, input logic [31:0] d);
        ocd_write_enable = 1'b1;
        ocd_rw_addr      = a;
        ocd_write_word   = d;
        @(negedge clk);
        ocd_write_enable = 1'b0;
    endtask

    task automatic load_prog(input int base);
        foreach (prog[i]) ocd_wr(MW'(base + i), prog[i]);
        prog.delete();
    endtask

    task automatic ocd_rd(input logic [MW-1:0] a, output logic [31:0] d);
        ocd_read_enable = 1'b1;
        ocd_rw_addr     = a;
        @(negedge clk);
        ocd_read_enable = 1'b0;
        d = ocd_mem_word_out;
    endtask

    task automatic launch(input logic [31:0] a);
        start_address = a;
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (processor_paused) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        tests++;
        if (processor_paused !== 1'b1 || TXD !== 1'b1 || peek_pc !== 32'd0 || peek_ir !== 32'd0 ||
            peek_mem_write_en !== 4'd0 || ocd_mem_enable_out !== 1'b0 || ocd_mem_word_out !== 32'd0) begin
            fails++;
            $display("FAIL reset: got paused=%b txd=%b pc=%h ir=%h en=%h ocd_en=%b ocd_word=%h, required 1 1 0 0 0 0 0",
                     processor_paused, TXD, peek_pc, peek_ir, peek_mem_write_en, ocd_mem_enable_out, ocd_mem_word_out);
        end
    endtask

    task automatic test_ocd;
        ocd_wr(12'd5, 32'hDEADBEEF);
        ocd_read_enable = 1'b1;
        ocd_rw_addr     = 12'd5;
        tests++;
        if (ocd_mem_enable_out !== 1'b0) begin
            fails++;
            $display("FAIL ocd_early: got enable=%b, required 0", ocd_mem_enable_out);
        end
        @(negedge clk);
        ocd_read_enable = 1'b0;
        tests++;
        if (ocd_mem_enable_out !== 1'b1 || ocd_mem_word_out !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL ocd_read: got enable=%b word=%h, required 1 deadbeef", ocd_mem_enable_out, ocd_mem_word_out);
        end
        @(negedge clk);
        tests++;
        if (ocd_mem_enable_out !== 1'b0) begin
            fails++;
            $display("FAIL ocd_pulse: got enable=%b, required 0", ocd_mem_enable_out);
        end
    endtask

    task automatic test_alu_store;
        bit ok;
        logic [31:0] d;
        prog = '{32'h00500093, 32'h00108133, 32'h10202023, 32'h00000073};
        load_prog(0);
        sb_q.push_back('{4'hF, 12'h040, 32'h0000000A, 32'hFFFFFFFF});
        launch(32'h0);
        wait_halt(ok);
        tests++;
        if (!ok || sb_q.size() != 0) begin
            fails++;
            $display("FAIL alu_store_done: got halted=%b pending=%0d, required 1 0", ok, sb_q.size());
        end
        ocd_rd(12'h040, d);
        tests++;
        if (d !== 32'h0000000A) begin
            fails++;
            $display("FAIL alu_store_ram: got %h, required 0000000a", d);
        end
    endtask

    task automatic test_lane_store;
        bit ok;
        logic [31:0] d;
        prog = '{32'hFFFFF1B7, 32'h40C1D213, 32'h004001A3, 32'h00000073};
        load_prog(16);
        sb_q.push_back('{4'b1000, 12'h000, 32'hFF000000, 32'hFF000000});
        launch(32'h40);
        wait_halt(ok);
        tests++;
        if (!ok || sb_q.size() != 0) begin
            fails++;
            $display("FAIL lane_store_done: got halted=%b pending=%0d, required 1 0", ok, sb_q.size());
        end
        ocd_rd(12'h000, d);
        tests++;
        if (d !== 32'hFF500093) begin
            fails++;
            $display("FAIL lane_store_ram: got %h, required ff500093", d);
        end
    endtask

    task automatic test_load;
        bit ok;
        ocd_wr(12'h100, 32'h80FF7F01);
        prog = '{32'h40300403, 32'h40205483, 32'h40802223, 32'h40902423, 32'h00000073};
        load_prog(12'hC0);
        sb_q.push_back('{4'hF, 12'h101, 32'hFFFFFF80, 32'hFFFFFFFF});
        sb_q.push_back('{4'hF, 12'h102, 32'h000080FF, 32'hFFFFFFFF});
        launch(32'h300);
        wait_halt(ok);
        tests++;
        if (!ok || sb_q.size() != 0) begin
            fails++;
            $display("FAIL load_done: got halted=%b pending=%0d, required 1 0", ok, sb_q.size());
        end
    endtask

    task automatic test_branch;
        bit ok;
        prog = '{32'hFFF00513, 32'h00A06463, 32'h60002223, 32'h60A02023, 32'h00000073};
        load_prog(12'h140);
        sb_q.push_back('{4'hF, 12'h180, 32'hFFFFFFFF, 32'hFFFFFFFF});
        launch(32'h500);
        wait_halt(ok);
        tests++;
        if (!ok || sb_q.size() != 0) begin
            fails++;
            $display("FAIL branch_done: got halted=%b pending=%0d, required 1 0", ok, sb_q.size());
        end
    endtask

    task automatic test_uart;
        bit ok;
        logic [9:0] frame;
        logic [31:0] d;
        prog = '{32'h04100293, 32'h20000337, 32'h00530023, 32'h0A500293, 32'h00530023, 32'h00000073};
        load_prog(12'h1C0);
        uart_q.push_back(8'h41);
        uart_q.push_back(8'hA5);
        launch(32'h700);
        for (int f = 0; f < 2; f++) begin
            frame = {1'b1, uart_q.pop_front(), 1'b0};
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (TXD === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL uart_start%0d: got no start bit within 200 cycles, required one", f);
            end else
                for (int b = 0; b < 10; b++) begin
                    tests++;
                    if (TXD !== frame[b]) begin
                        fails++;
                        $display("FAIL uart_bit f%0d b%0d: got %b, required %b", f, b, TXD, frame[b]);
                    end
                    repeat (4) @(negedge clk);
                end
        end
        wait_halt(ok);
        tests++;
        if (!ok || TXD !== 1'b1) begin
            fails++;
            $display("FAIL uart_done: got halted=%b txd=%b, required 1 1", ok, TXD);
        end
        ocd_rd(12'h000, d);
        tests++;
        if (d !== 32'hFF500093) begin
            fails++;
            $display("FAIL uart_ram_untouched: got %h, required ff500093", d);
        end
    endtask

    task automatic test_ecall;
        bit ok = 1'b0;
        prog = '{32'h00100393, 32'h00138393, 32'h00000073};
        load_prog(12'h080);
        launch(32'h200);
        for (int i = 0; i < 100; i++) begin
            if (processor_paused) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok || peek_pc !== 32'h208 || peek_ir !== 32'h00000073) begin
            fails++;
            $display("FAIL ecall: got halted=%b pc=%h ir=%h, required 1 208 00000073", ok, peek_pc, peek_ir);
        end
        repeat (10) @(negedge clk);
        tests++;
        if (processor_paused !== 1'b1 || peek_pc !== 32'h208) begin
            fails++;
            $display("FAIL ecall_hold: got paused=%b pc=%h, required 1 208", processor_paused, peek_pc);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sync_reset;
        bit ok = 1'b0;
        launch(32'h700);
        for (int i = 0; i < 200; i++) begin
            if (TXD === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_frame: got no start bit within 200 cycles, required one");
        end
        repeat (6) @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        tests++;
        if (processor_paused !== 1'b1 || TXD !== 1'b1 || peek_pc !== 32'd0 || peek_ir !== 32'd0 ||
            peek_mem_write_en !== 4'd0 || ocd_mem_word_out !== 32'd0) begin
            fails++;
            $display("FAIL mid_reset: got paused=%b txd=%b pc=%h ir=%h en=%h ocd_word=%h, required 1 1 0 0 0 0",
                     processor_paused, TXD, peek_pc, peek_ir, peek_mem_write_en, ocd_mem_word_out);
        end
        start = 1'b0;
        sync_reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (TXD !== 1'b1 || processor_paused !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL post_reset_idle: got activity after reset, required TXD=1 paused=1");
        end
    endtask

    initial begin
        sync_reset = 1'b1;
        reset_n = 1'b1;
        ocd_read_enable = 1'b0;
        ocd_write_enable = 1'b0;
        ocd_rw_addr = '0;
        ocd_write_word = '0;
        ocd_reg_read_addr = '0;
        ocd_reg_we = 1'b0;
        ocd_reg_write_addr = '0;
        ocd_reg_write_data = '0;
        start = 1'b0;
        start_address = '0;
        repeat (3) @(negedge clk);
        sync_reset = 1'b0;
        @(negedge clk);
        test_reset;
        test_ocd;
        test_alu_store;
        test_lane_store;
        test_load;
        test_branch;
        test_uart;
        test_ecall;
        test_sync_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
